// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: program counter, branch redirect and the IF/ID
// pipeline register that feeds the decode/control stage.
module fetch_stage #(
  parameter int unsigned        ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [31:0]              imem_data,
  input  logic                     ex_beq,
  input  logic                     ex_bne,
  input  logic                     ex_zero,
  input  logic [ADDR_W-1:0]        ex_pc,
  input  logic signed [ADDR_W-1:0] ex_offset,
  output logic [31:0]              if_instr,
  output logic [ADDR_W-1:0]        if_pc,
  output logic                     if_valid,
  output logic [10:0]              opcode,
  output logic                     br_taken,
  output logic [31:0]              fetch_count
);

  typedef enum logic {S_RESET, S_RUN} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pc_p0, pc_p0_nxt;
  logic [31:0]         instr_p1, instr_p1_nxt;
  logic [ADDR_W-1:0]   pc_p1, pc_p1_nxt;
  logic                vld_p1, vld_p1_nxt;
  logic [31:0]         cnt, cnt_nxt;
  logic [ADDR_W-1:0]   target;

  // Word offset scaled to bytes; everything wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] branch_target(
    input logic [ADDR_W-1:0]        base,
    input logic signed [ADDR_W-1:0] off_words
  );
    logic [ADDR_W-1:0] off_bytes;
    off_bytes = off_words << 2;
    return base + off_bytes;
  endfunction

  function automatic logic [ADDR_W-1:0] seq_pc(input logic [ADDR_W-1:0] pc);
    return pc + {{(ADDR_W-3){1'b0}}, 3'd4};
  endfunction

  assign br_taken = (ex_beq & ex_zero) | (ex_bne & ~ex_zero);
  assign target   = branch_target(ex_pc, ex_offset);

  always_comb begin
    state_nxt    = state;
    pc_p0_nxt    = pc_p0;
    instr_p1_nxt = instr_p1;
    pc_p1_nxt    = pc_p1;
    vld_p1_nxt   = vld_p1;
    cnt_nxt      = cnt;

    case (state)
      S_RESET: state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_RESET;
    endcase

    // A taken branch squashes the wrong-path word even while stalled.
    if (br_taken) begin
      pc_p0_nxt    = target;
      instr_p1_nxt = 32'h0;
      pc_p1_nxt    = '0;
      vld_p1_nxt   = 1'b0;
    end else if (!stall) begin
      pc_p0_nxt    = seq_pc(pc_p0);
      instr_p1_nxt = imem_data;
      pc_p1_nxt    = pc_p0;
      vld_p1_nxt   = 1'b1;
      cnt_nxt      = cnt + 32'd1;
    end
  end

  // IF -> ID boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RESET;
      pc_p0    <= RESET_PC;
      instr_p1 <= 32'h0;
      pc_p1    <= '0;
      vld_p1   <= 1'b0;
      cnt      <= 32'd0;
    end else begin
      state    <= state_nxt;
      pc_p0    <= pc_p0_nxt;
      instr_p1 <= instr_p1_nxt;
      pc_p1    <= pc_p1_nxt;
      vld_p1   <= vld_p1_nxt;
      cnt      <= cnt_nxt;
    end
  end

  assign imem_addr   = pc_p0;
  assign if_instr    = instr_p1;
  assign if_pc       = pc_p1;
  assign if_valid    = vld_p1;
  assign opcode      = instr_p1[31:21];
  assign fetch_count = cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a 64-bit and an 8-bit instance share control stimulus and
// are compared every cycle against a queue-free behavioural model, plus literal pins.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, ex_beq, ex_bne, ex_zero, mem_mode;
  logic [63:0] ex_pc, ex_offset;

  logic [63:0] addr_a, ifpc_a;
  logic [7:0]  addr_b, ifpc_b;
  logic [31:0] data_a, data_b, instr_a, instr_b, cnt_a, cnt_b;
  logic        vld_a, vld_b, bt_a, bt_b;
  logic [10:0] op_a, op_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a, input logic mode);
    logic [31:0] idx;
    idx = a[33:2];
    if (!mode) return 32'h8B00_0000 + idx;
    return (idx * 32'h9E37_79B1) ^ 32'h8B5A_0000;
  endfunction

  always_comb data_a = mem_word(addr_a, mem_mode);
  always_comb data_b = mem_word({56'd0, addr_b}, mem_mode);

  fetch_stage #(.ADDR_W(64), .RESET_PC(64'h0)) dut_a (
    .clk(clk), .rst(rst), .stall(stall), .imem_addr(addr_a), .imem_data(data_a),
    .ex_beq(ex_beq), .ex_bne(ex_bne), .ex_zero(ex_zero), .ex_pc(ex_pc),
    .ex_offset(ex_offset), .if_instr(instr_a), .if_pc(ifpc_a), .if_valid(vld_a),
    .opcode(op_a), .br_taken(bt_a), .fetch_count(cnt_a)
  );

  fetch_stage #(.ADDR_W(8), .RESET_PC(8'hF0)) dut_b (
    .clk(clk), .rst(rst), .stall(stall), .imem_addr(addr_b), .imem_data(data_b),
    .ex_beq(ex_beq), .ex_bne(ex_bne), .ex_zero(ex_zero), .ex_pc(ex_pc[7:0]),
    .ex_offset(ex_offset[7:0]), .if_instr(instr_b), .if_pc(ifpc_b), .if_valid(vld_b),
    .opcode(op_b), .br_taken(bt_b), .fetch_count(cnt_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: index 0 = 64-bit instance, index 1 = 8-bit instance.
  logic [63:0] m_pc[2], m_ipc[2], mask[2], rpc[2];
  logic [31:0] m_instr[2], m_cnt[2];
  logic        m_vld[2];
  bit          started = 0;

  initial begin
    mask[0] = 64'hFFFF_FFFF_FFFF_FFFF; mask[1] = 64'hFF;
    rpc[0]  = 64'h0;                   rpc[1]  = 64'hF0;
  end

  function automatic logic model_taken();
    return (ex_beq && ex_zero) || (ex_bne && !ex_zero);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_pc[k] = rpc[k]; m_instr[k] = 0; m_ipc[k] = 0; m_vld[k] = 0; m_cnt[k] = 0;
      end else if (model_taken()) begin
        m_pc[k] = (ex_pc + ex_offset * 64'd4) & mask[k];
        m_instr[k] = 0; m_ipc[k] = 0; m_vld[k] = 0;
      end else if (!stall) begin
        m_instr[k] = mem_word(m_pc[k], mem_mode);
        m_ipc[k]   = m_pc[k];
        m_pc[k]    = (m_pc[k] + 64'd4) & mask[k];
        m_vld[k]   = 1'b1;
        m_cnt[k]   = m_cnt[k] + 32'd1;
      end
    end
    if (rst) started = 1;
  end

  always @(posedge clk) begin
    #2;
    if (started) begin
      chk("a.imem_addr",   addr_a,  m_pc[0]);
      chk("a.if_instr",    instr_a, m_instr[0]);
      chk("a.if_pc",       ifpc_a,  m_ipc[0]);
      chk("a.if_valid",    vld_a,   m_vld[0]);
      chk("a.opcode",      op_a,    m_instr[0][31:21]);
      chk("a.fetch_count", cnt_a,   m_cnt[0]);
      chk("a.br_taken",    bt_a,    model_taken());
      chk("b.imem_addr",   addr_b,  m_pc[1]);
      chk("b.if_instr",    instr_b, m_instr[1]);
      chk("b.if_pc",       ifpc_b,  m_ipc[1]);
      chk("b.if_valid",    vld_b,   m_vld[1]);
      chk("b.opcode",      op_b,    m_instr[1][31:21]);
      chk("b.fetch_count", cnt_b,   m_cnt[1]);
      chk("b.br_taken",    bt_b,    model_taken());
    end
  end

  task automatic cyc();
    @(posedge clk);
    #3;
  endtask

  task automatic clr();
    ex_beq = 0; ex_bne = 0; ex_zero = 0; ex_pc = 0; ex_offset = 0;
  endtask

  initial begin
    rst = 1; stall = 0; mem_mode = 0;
    clr();
    cyc(); cyc();
    chk("rst.addr_a", addr_a, 64'h0);
    chk("rst.addr_b", addr_b, 8'hF0);
    chk("rst.instr", instr_a, 0);
    chk("rst.opcode", op_a, 0);
    chk("rst.if_pc", ifpc_a, 0);
    chk("rst.valid", vld_a, 0);
    chk("rst.count", cnt_a, 0);
    chk("rst.br_taken", bt_a, 0);

    rst = 0;
    cyc(); cyc();
    chk("run.if_pc4", ifpc_a, 64'd4);
    chk("run.addr8", addr_a, 64'd8);
    chk("run.opcode", op_a, 11'b10001011000);
    chk("run.count2", cnt_a, 2);
    chk("run.b_addr", addr_b, 8'hF8);

    stall = 1;
    repeat (3) begin
      cyc();
      chk("stall.addr", addr_a, 64'd8);
      chk("stall.if_pc", ifpc_a, 64'd4);
      chk("stall.count", cnt_a, 2);
    end
    stall = 0;
    cyc();
    chk("resume.if_pc", ifpc_a, 64'd8);
    chk("resume.instr", instr_a, 32'h8B00_0002);
    cyc();
    chk("run.if_pc12", ifpc_a, 64'd12);
    chk("run.count4", cnt_a, 4);
    chk("run.addr16", addr_a, 64'd16);

    ex_beq = 1; ex_zero = 1; ex_pc = 64'd16; ex_offset = 64'd3;
    #1 chk("cbz.br_taken", bt_a, 1);
    cyc(); clr();
    chk("cbz.addr28", addr_a, 64'd28);
    chk("cbz.valid0", vld_a, 0);
    chk("cbz.instr0", instr_a, 0);
    cyc();
    chk("cbz.if_pc28", ifpc_a, 64'd28);
    chk("cbz.instr", instr_a, 32'h8B00_0007);

    ex_bne = 1; ex_zero = 1; ex_pc = 64'd40; ex_offset = -64'sd2;
    #1 chk("cbnz.nt", bt_a, 0);
    cyc();
    chk("cbnz.nt.addr", addr_a, 64'd36);
    ex_zero = 0;
    #1 chk("cbnz.t", bt_a, 1);
    cyc(); clr();
    chk("cbnz.addr32", addr_a, 64'd32);
    chk("cbnz.b_addr32", addr_b, 8'd32);

    stall = 1; ex_beq = 1; ex_zero = 1; ex_pc = 64'd248; ex_offset = 0;
    cyc(); clr(); stall = 0;
    chk("stalltk.addr", addr_a, 64'd248);
    chk("stalltk.valid", vld_a, 0);
    cyc();
    chk("wrap.b252", addr_b, 8'd252);
    cyc();
    chk("wrap.b0", addr_b, 8'd0);
    chk("wrap.a256", addr_a, 64'd256);
    ex_beq = 1; ex_zero = 1; ex_pc = 0; ex_offset = 64'hFFFF_FFFF_FFFF_FFFF;
    cyc(); clr();
    chk("back.b252", addr_b, 8'd252);
    chk("back.a", addr_a, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc();
    chk("back.a_wrap", addr_a, 64'd0);

    stall = 1;
    cyc();
    rst = 1; ex_beq = 1; ex_zero = 1; ex_pc = 64'd100;
    cyc();
    rst = 0; stall = 0; clr();
    chk("midrst.addr_a", addr_a, 64'h0);
    chk("midrst.addr_b", addr_b, 8'hF0);
    chk("midrst.valid", vld_a, 0);
    chk("midrst.count", cnt_a, 0);
    chk("midrst.instr", instr_a, 0);

    mem_mode = 1;
    repeat (3000) begin
      int o;
      stall   = ($urandom % 5) == 0;
      ex_beq  = ($urandom % 8) == 0;
      ex_bne  = ($urandom % 8) == 0;
      ex_zero = $urandom % 2;
      ex_pc   = ($urandom % 4 == 0) ? {$urandom, $urandom} : {32'd0, $urandom % 1024};
      o = int'($urandom_range(0, 63)) - 32;
      ex_offset = {{32{o[31]}}, o};
      rst     = ($urandom % 64) == 0;
      cyc();
    end
    rst = 0; stall = 0; clr();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
